// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART state encodings, data width and bit-timing macros
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef UART_BIT_DIV
`define UART_BIT_DIV(clk_hz, baud) ((clk_hz) / (baud))
`endif
`ifndef UART_HALF_DIV
`define UART_HALF_DIV(clk_hz, baud) (((clk_hz) / (baud)) / 2)
`endif

package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
// ============================================================================
// uart_rx_bit_timer : 16-bit bit-period counter with full and half-bit ticks
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_bit_timer #(
    parameter int BIT_DIV  = 10,
    parameter int HALF_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic half_sel,
    output logic tick,
    output logic half_tick
);

    localparam logic [15:0] C_BIT_LAST  = 16'(BIT_DIV - 1);
    localparam logic [15:0] C_HALF_LAST = 16'(HALF_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        w_wrap;

    // With half_sel the period is shortened so the start bit is checked mid-bit.
    always_comb begin
        half_tick = half_sel && (cnt_q == C_HALF_LAST);
        tick      = !half_sel && (cnt_q == C_BIT_LAST);
        w_wrap    = tick || half_tick;
        cnt_d     = (clear || w_wrap) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_8n1.sv
// ============================================================================
// uart_rx_8n1 : start-aligned UART receiver, 8 data bits, 1 stop bit
// Optional parity bit enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_Period = 50000000,
    parameter int Buad_Rate  = 9600,
    parameter bit Parity_Odd = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    output logic              rx_busy
);

    localparam int BIT_DIV  = `UART_BIT_DIV(CLK_Period, Buad_Rate);
    localparam int HALF_DIV = `UART_HALF_DIV(CLK_Period, Buad_Rate);

    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;
    uart_state_e       state_q;
    uart_state_e       state_d;
    logic [2:0]        idx_q;
    logic [2:0]        idx_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              ferr_q;
    logic              ferr_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q;
    logic              par_d;
    logic              perr_q;
    logic              perr_d;
`endif

    logic w_fall;
    logic w_clear;
    logic w_half_sel;
    logic w_tick;
    logic w_half_tick;

    assign w_fall = prev_q & ~sync2_q;

    uart_rx_bit_timer #(
        .BIT_DIV  (BIT_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .half_sel  (w_half_sel),
        .tick      (w_tick),
        .half_tick (w_half_tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        w_clear    = 1'b0;
        w_half_sel = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_fall) begin
                    state_d = ST_START;
                    w_clear = 1'b1;
                end
            end
            ST_START: begin
                w_half_sel = 1'b1;
                if (w_half_tick) begin
                    if (!sync2_q) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                        w_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    shift_d[idx_q] = sync2_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    par_d   = sync2_q;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ((^shift_q) ^ par_q) != Parity_Odd;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            // A held-low line stays here so it reports a single framing error.
            ST_BREAK: begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    // Parity sense has no effect without the parity bit.
    assign rx_parity_err = Parity_Odd & 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
// ============================================================================
// tb_uart_rx_8n1 : self-checking bench for uart_rx_8n1 with a frame-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_8n1;

    localparam int BIT_CLKS = 10;
    localparam bit PODD     = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN   = 1'b1;
`else
    localparam bit PAR_EN   = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] got_data[$];
    logic       got_perr[$];
    int         got_t[$];
    int         fe_cnt   = 0;
    int         both_cnt = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_8n1 #(
        .CLK_Period (1000000),
        .Buad_Rate  (100000),
        .Parity_Odd (PODD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_data.push_back(rx_data);
            got_perr.push_back(rx_parity_err);
            got_t.push_back(cyc);
        end
        if (rx_frame_err) fe_cnt++;
        if (rx_valid && rx_frame_err) both_cnt++;
    end

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ PODD;
    endfunction

    function automatic logic exp_perr(input logic [7:0] d, input logic p);
        return PAR_EN ? (((^d) ^ p) != PODD) : 1'b0;
    endfunction

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
        if (PAR_EN) send_bit(p, BIT_CLKS);
        send_bit(stop, BIT_CLKS);
    endtask

    task automatic idle_bits(input int n);
        if (n > 0) send_bit(1'b1, n * BIT_CLKS);
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_perr.delete();
        got_t.delete();
        fe_cnt   = 0;
        both_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h want=00", rx_data);
        end
        total++;
        if ({rx_valid, rx_frame_err, rx_parity_err, rx_busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000",
                            {rx_valid, rx_frame_err, rx_parity_err, rx_busy});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_bits(2);
        total++;
        if (rx_busy !== 1'b0 || got_data.size() != 0) begin
            bad++; $display("FAIL reset_idle busy=%b valids=%0d want busy=0 valids=0",
                            rx_busy, got_data.size());
        end
    endtask

    task automatic test_single();
        int t0;
        logic p;
        clear_mon();
        p = good_par(8'hA5);
        @(posedge clk); #1;
        t0 = cyc;
        send_frame(8'hA5, p, 1'b1);
        idle_bits(2);
        total++;
        if (got_data.size() != 1) begin
            bad++; $display("FAIL a5_count got=%0d want=1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 8'hA5) begin
                bad++; $display("FAIL a5_data got=%h want=a5", got_data[0]);
            end
            total++;
            if (got_perr[0] !== 1'b0) begin
                bad++; $display("FAIL a5_perr got=%b want=0", got_perr[0]);
            end
            total++;
            if ((got_t[0] - t0) < 95 + 10 * int'(PAR_EN) || (got_t[0] - t0) > 99 + 10 * int'(PAR_EN)) begin
                bad++; $display("FAIL a5_latency got=%0d want=%0d..%0d", got_t[0] - t0,
                                95 + 10 * int'(PAR_EN), 99 + 10 * int'(PAR_EN));
            end
        end
        total++;
        if (fe_cnt != 0 || rx_busy !== 1'b0) begin
            bad++; $display("FAIL a5_idle fe=%0d busy=%b want fe=0 busy=0", fe_cnt, rx_busy);
        end
        last_good = 8'hA5;
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p;
        int         gap;
        for (int n = 0; n < 10; n++) begin
            clear_mon();
            d   = 8'($urandom);
            p   = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            gap = $urandom_range(0, 3);
            send_frame(d, p, 1'b1);
            total++;
            if (got_data.size() != 1 || fe_cnt != 0) begin
                bad++; $display("FAIL rand_count n=%0d valids=%0d fe=%0d want 1/0",
                                n, got_data.size(), fe_cnt);
            end else if (got_data[0] !== d || got_perr[0] !== exp_perr(d, p)) begin
                bad++; $display("FAIL rand_data n=%0d got=%h/%b want=%h/%b",
                                n, got_data[0], got_perr[0], d, exp_perr(d, p));
            end
            last_good = d;
            idle_bits(gap);
        end
    endtask

    task automatic test_glitch();
        bit dropped;
        clear_mon();
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        total++;
        if (rx_busy !== 1'b1) begin
            bad++; $display("FAIL glitch_busy got=%b want=1", rx_busy);
        end
        dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rx_busy) begin
                dropped = 1'b1;
                break;
            end
        end
        total++;
        if (!dropped) begin
            bad++; $display("FAIL glitch_release busy=%b want=0 within 20 clk", rx_busy);
        end
        idle_bits(3);
        total++;
        if (got_data.size() != 0 || fe_cnt != 0 || rx_data !== last_good) begin
            bad++; $display("FAIL glitch_strobes valids=%0d fe=%0d data=%h want 0/0/%h",
                            got_data.size(), fe_cnt, rx_data, last_good);
        end
    endtask

    task automatic test_break();
        clear_mon();
        send_frame(8'h3C, good_par(8'h3C), 1'b0);
        send_bit(1'b0, 30 * BIT_CLKS);
        total++;
        if (fe_cnt != 1 || both_cnt != 0) begin
            bad++; $display("FAIL break_fe got=%0d both=%0d want=1/0", fe_cnt, both_cnt);
        end
        total++;
        if (got_data.size() != 0 || rx_data !== last_good) begin
            bad++; $display("FAIL break_data valids=%0d data=%h want 0/%h",
                            got_data.size(), rx_data, last_good);
        end
        total++;
        if (rx_busy !== 1'b1) begin
            bad++; $display("FAIL break_busy got=%b want=1", rx_busy);
        end
        idle_bits(2);
        total++;
        if (rx_busy !== 1'b0) begin
            bad++; $display("FAIL break_exit busy=%b want=0", rx_busy);
        end
        clear_mon();
        send_frame(8'h81, good_par(8'h81), 1'b1);
        idle_bits(1);
        total++;
        if (got_data.size() != 1 || rx_data !== 8'h81 || fe_cnt != 0) begin
            bad++; $display("FAIL break_recover valids=%0d data=%h fe=%0d want 1/81/0",
                            got_data.size(), rx_data, fe_cnt);
        end
        last_good = 8'h81;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h00, good_par(8'h00), 1'b1);
        send_frame(8'hFF, good_par(8'hFF), 1'b1);
        idle_bits(1);
        total++;
        if (got_data.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d want=2", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== 8'h00 || got_data[1] !== 8'hFF) begin
                bad++; $display("FAIL b2b_data got=%h,%h want=00,ff", got_data[0], got_data[1]);
            end
        end
        total++;
        if (fe_cnt != 0) begin
            bad++; $display("FAIL b2b_fe got=%0d want=0", fe_cnt);
        end
        last_good = 8'hFF;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h6B;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(d[i], BIT_CLKS);
        rx = d[4];
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy} !== 12'h000) begin
            bad++; $display("FAIL midreset_outputs got=%h/%b%b%b%b want=00/0000", rx_data,
                            rx_valid, rx_frame_err, rx_parity_err, rx_busy);
        end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_good = 8'h00;
        idle_bits(2);
        clear_mon();
        send_frame(8'h55, good_par(8'h55), 1'b1);
        idle_bits(1);
        total++;
        if (got_data.size() != 1 || rx_data !== 8'h55) begin
            bad++; $display("FAIL midreset_recover valids=%0d data=%h want 1/55",
                            got_data.size(), rx_data);
        end
        last_good = 8'h55;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        for (int p = 0; p < 2; p++) begin
            clear_mon();
            send_frame(8'h01, 1'(p), 1'b1);
            idle_bits(1);
            total++;
            if (got_data.size() != 1 || got_data[0] !== 8'h01) begin
                bad++; $display("FAIL parity_data p=%0d valids=%0d want 1 byte 01", p, got_data.size());
            end else if (got_perr[0] !== exp_perr(8'h01, 1'(p))) begin
                bad++; $display("FAIL parity_err p=%0d got=%b want=%b",
                                p, got_perr[0], exp_perr(8'h01, 1'(p)));
            end
        end
        last_good = 8'h01;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_random();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        total++;
        if (both_cnt != 0) begin
            bad++; $display("FAIL valid_with_fe got=%0d want=0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
